fb_rect_writer: RTL and testbench

//  Write-side engine for the 640x480 frame-buffer image memory that the VGA scan-out reads.

---
 rtl/fb_rect_writer_pkg.sv | 31 +++
 rtl/fb_rect_writer_if.sv | 33 +++
 rtl/fb_rect_writer.sv | 130 +++++++++++++
 tb/tb_fb_rect_writer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fb_rect_writer_pkg.sv
// Shared constants for the frame-buffer write engine and the scan-out side.
// Holds the visible raster size, bus widths, BGR pixel layout, FSM state encodings
// and the shift/add row-base helper (640 = 512 + 128, no multiplier).
package fb_rect_writer_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned VActive = 480;
  localparam int unsigned AddrW   = 20;
  localparam int unsigned CoordW  = 10;
  localparam int unsigned DataW   = 24;

  // Pixel layout: {B[23:16], G[15:8], R[7:0]}
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } bgr_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClip = 2'd1;
  localparam logic [1:0] StFill = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // y * 640 as (y << 9) + (y << 7)
  function automatic logic [AddrW-1:0] row_base_of(input logic [CoordW-1:0] y);
    logic [AddrW-1:0] y_ext;
    y_ext = AddrW'(y);
    return (y_ext << 9) + (y_ext << 7);
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command + frame-buffer write bundle for fb_rect_writer.
//  start/x0/y0/w/h/color : rectangle-fill command, sampled when ready=1
//  grant                 : memory accepts the current write
//  ready/done            : idle flag and one-cycle completion pulse
//  we/addr/data          : linear frame-buffer write port
// master = command source / memory side, slave = the writer engine.
interface fb_rect_writer_if;
  import fb_rect_writer_pkg::*;

  logic              start;
  logic [CoordW-1:0] x0;
  logic [CoordW-1:0] y0;
  logic [CoordW-1:0] w;
  logic [CoordW-1:0] h;
  logic [DataW-1:0]  color;
  logic              grant;
  logic              ready;
  logic              done;
  logic              we;
  logic [AddrW-1:0]  addr;
  logic [DataW-1:0]  data;

  modport master (
    output start, x0, y0, w, h, color, grant,
    input  ready, done, we, addr, data
  );

  modport slave (
    input  start, x0, y0, w, h, color, grant,
    output ready, done, we, addr, data
  );

endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the 640x480 frame buffer.
// Latches one command, clips it to the visible area, then issues one write per pixel
// at addr = y*640 + x, stalling while grant is low.
//  clk : clock shared with the frame-buffer write port
//  rst : asynchronous active-high reset
//  bus : fb_rect_writer_if.slave (command in, write port out)
module fb_rect_writer
  import fb_rect_writer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  fb_rect_writer_if.slave bus
);

  localparam logic [CoordW:0] HEnd = HActive;
  localparam logic [CoordW:0] VEnd = VActive;

  logic [1:0]        state_q, state_d;
  logic [CoordW-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [DataW-1:0]  color_q, color_d;
  logic [CoordW-1:0] x_q, x_d, y_q, y_d;
  logic [AddrW-1:0]  row_base_q, row_base_d;
  // Set after the last pixel is consumed: one quiet cycle before the done pulse.
  logic              retire_q, retire_d;

  logic [CoordW:0] x_sum, y_sum, x_end, y_end, x_nxt, y_nxt;
  logic            empty;

  always_comb begin
    // Widened by one bit so x0+w / y0+h cannot overflow.
    x_sum = {1'b0, x0_q} + {1'b0, w_q};
    y_sum = {1'b0, y0_q} + {1'b0, h_q};
    x_end = (x_sum > HEnd) ? HEnd : x_sum;
    y_end = (y_sum > VEnd) ? VEnd : y_sum;
    x_nxt = {1'b0, x_q} + 1'b1;
    y_nxt = {1'b0, y_q} + 1'b1;
    empty = (w_q == '0) || (h_q == '0) || ({1'b0, x0_q} >= HEnd) || ({1'b0, y0_q} >= VEnd);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    retire_d   = retire_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          w_d     = bus.w;
          h_d     = bus.h;
          color_d = bus.color;
          state_d = StClip;
        end
      end
      StClip: begin
        if (empty) begin
          state_d = StDone;
        end else begin
          row_base_d = row_base_of(y0_q);
          x_d        = x0_q;
          y_d        = y0_q;
          retire_d   = 1'b0;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (retire_q) begin
          state_d = StDone;
        end else if (bus.grant) begin
          if (x_nxt < x_end) begin
            x_d = x_q + 1'b1;
          end else if (y_nxt < y_end) begin
            x_d        = x0_q;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + AddrW'(HActive);
          end else begin
            retire_d = 1'b1;
          end
        end
      end
      StDone: begin
        retire_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      retire_q   <= retire_d;
    end
  end

  // Outputs decode directly from state so reset drops we without waiting for a clock.
  assign bus.ready = (state_q == StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.we    = (state_q == StFill) && !retire_q;
  assign bus.addr  = row_base_q + AddrW'(x_q);
  assign bus.data  = color_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle of outputs, then advance to the next cycle.
  task automatic expect_cycle(input string tag, input logic exp_we, input int exp_addr,
                              input int exp_data, input logic exp_done);
    check({tag, ".we"}, 32'(bus.we), 32'(exp_we));
    if (exp_we) begin
      check({tag, ".addr"}, 32'(bus.addr), 32'(exp_addr));
      check({tag, ".data"}, 32'(bus.data), 32'(exp_data));
    end
    check({tag, ".done"}, 32'(bus.done), 32'(exp_done));
    step();
  endtask

  // Present a command for one edge from IDLE; returns in cycle 1.
  task automatic issue(input int x0, input int y0, input int w, input int h, input int color);
    check("issue.ready", 32'(bus.ready), 32'd1);
    bus.x0    = 10'(x0);
    bus.y0    = 10'(y0);
    bus.w     = 10'(w);
    bus.h     = 10'(h);
    bus.color = 24'(color);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("issue.busy", 32'(bus.ready), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.w     = '0;
    bus.h     = '0;
    bus.color = '0;
    bus.grant = 1'b1;
    step();
    step();
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.done",  32'(bus.done),  32'd0);
    check("rst.we",    32'(bus.we),    32'd0);
    check("rst.addr",  32'(bus.addr),  32'd0);
    check("rst.data",  32'(bus.data),  32'd0);
    rst = 1'b0;
    step();

    // 1: 2x2 at origin
    issue(0, 0, 2, 2, 'hFF0000);
    expect_cycle("t1.c1", 1'b0, 0,   0,         1'b0);
    expect_cycle("t1.c2", 1'b1, 0,   'hFF0000,  1'b0);
    expect_cycle("t1.c3", 1'b1, 1,   'hFF0000,  1'b0);
    expect_cycle("t1.c4", 1'b1, 640, 'hFF0000,  1'b0);
    expect_cycle("t1.c5", 1'b1, 641, 'hFF0000,  1'b0);
    expect_cycle("t1.c6", 1'b0, 0,   0,         1'b0);
    expect_cycle("t1.c7", 1'b0, 0,   0,         1'b1);
    check("t1.c8.ready", 32'(bus.ready), 32'd1);
    check("t1.c8.done",  32'(bus.done),  32'd0);

    // 2: bottom-right corner, clipped to 2x1
    issue(638, 479, 10, 10, 'h00FF00);
    expect_cycle("t2.c1", 1'b0, 0,      0,        1'b0);
    expect_cycle("t2.c2", 1'b1, 307198, 'h00FF00, 1'b0);
    expect_cycle("t2.c3", 1'b1, 307199, 'h00FF00, 1'b0);
    expect_cycle("t2.c4", 1'b0, 0,      0,        1'b0);
    expect_cycle("t2.c5", 1'b0, 0,      0,        1'b1);

    // 3: empty commands (W=0, X0=640, Y0=480)
    issue(3, 3, 0, 5, 'h111111);
    expect_cycle("t3a.c1", 1'b0, 0, 0, 1'b0);
    expect_cycle("t3a.c2", 1'b0, 0, 0, 1'b1);
    check("t3a.c3.ready", 32'(bus.ready), 32'd1);
    issue(640, 0, 5, 5, 'h222222);
    expect_cycle("t3b.c1", 1'b0, 0, 0, 1'b0);
    expect_cycle("t3b.c2", 1'b0, 0, 0, 1'b1);
    check("t3b.c3.ready", 32'(bus.ready), 32'd1);
    issue(0, 480, 5, 5, 'h333333);
    expect_cycle("t3c.c1", 1'b0, 0, 0, 1'b0);
    expect_cycle("t3c.c2", 1'b0, 0, 0, 1'b1);

    // 4: grant pattern 1,0,0,1,1
    issue(5, 1, 3, 1, 'hC0FFEE);
    expect_cycle("t4.c1", 1'b0, 0, 0, 1'b0);
    bus.grant = 1'b1;
    expect_cycle("t4.c2", 1'b1, 645, 'hC0FFEE, 1'b0);
    bus.grant = 1'b0;
    expect_cycle("t4.c3", 1'b1, 646, 'hC0FFEE, 1'b0);
    bus.grant = 1'b0;
    expect_cycle("t4.c4", 1'b1, 646, 'hC0FFEE, 1'b0);
    bus.grant = 1'b1;
    expect_cycle("t4.c5", 1'b1, 646, 'hC0FFEE, 1'b0);
    bus.grant = 1'b1;
    expect_cycle("t4.c6", 1'b1, 647, 'hC0FFEE, 1'b0);
    expect_cycle("t4.c7", 1'b0, 0,   0,        1'b0);
    expect_cycle("t4.c8", 1'b0, 0,   0,        1'b1);

    // 5: start held with new fields while busy is ignored
    issue(10, 2, 2, 1, 'h123456);
    bus.x0    = 10'd100;
    bus.y0    = 10'd100;
    bus.w     = 10'd1;
    bus.h     = 10'd1;
    bus.color = 24'hABCDEF;
    bus.start = 1'b1;
    expect_cycle("t5.c1", 1'b0, 0,    0,        1'b0);
    expect_cycle("t5.c2", 1'b1, 1290, 'h123456, 1'b0);
    expect_cycle("t5.c3", 1'b1, 1291, 'h123456, 1'b0);
    expect_cycle("t5.c4", 1'b0, 0,    0,        1'b0);
    bus.start = 1'b0;
    expect_cycle("t5.c5", 1'b0, 0,    0,        1'b1);
    check("t5.c6.ready", 32'(bus.ready), 32'd1);
    step();
    check("t5.c7.ready", 32'(bus.ready), 32'd1);
    check("t5.c7.we",    32'(bus.we),    32'd0);

    // 6: reset in the middle of a fill
    issue(0, 10, 4, 2, 'h0000FF);
    expect_cycle("t6.c1", 1'b0, 0,    0,        1'b0);
    expect_cycle("t6.c2", 1'b1, 6400, 'h0000FF, 1'b0);
    check("t6.c3.we",   32'(bus.we),   32'd1);
    check("t6.c3.addr", 32'(bus.addr), 32'd6401);
    #2;
    rst = 1'b1;
    #1;
    check("t6.async.we",   32'(bus.we),   32'd0);
    check("t6.async.done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    check("t6.rel.ready", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6.idle.done", 32'(bus.done), 32'd0);
      check("t6.idle.we",   32'(bus.we),   32'd0);
    end
    issue(1, 0, 1, 1, 'h0F0F0F);
    expect_cycle("t6n.c1", 1'b0, 0, 0,        1'b0);
    expect_cycle("t6n.c2", 1'b1, 1, 'h0F0F0F, 1'b0);
    expect_cycle("t6n.c3", 1'b0, 0, 0,        1'b0);
    expect_cycle("t6n.c4", 1'b0, 0, 0,        1'b1);
    check("t6n.c5.ready", 32'(bus.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
